// File: rtl/vending_pkg.sv
// Shared vending datapath types: coin encoding, payout FSM states and coin values in nickel units.
package vending_pkg;

    typedef enum logic {
        NICKEL = 1'b0,
        DIME   = 1'b1
    } coin_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        JAM  = 2'd2
    } payout_state_e;

    localparam int NICKEL_VALUE    = 1;
    localparam int DIME_VALUE      = 2;
    localparam int MAX_CHANGE_CODE = 4;

    // Change codes above the largest legal value are paid as the largest legal value.
    function automatic logic [2:0] clamp_change(input logic [2:0] code);
        return (code > 3'(MAX_CHANGE_CODE)) ? 3'(MAX_CHANGE_CODE) : code;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of vend input, coin hopper handshake and status signals for the change dispenser.
interface change_dispenser_if;
    import vending_pkg::*;

    logic       vend_i;
    logic [2:0] change_i;
    logic       coin_ack_i;
    logic       clear_jam_i;
    logic       coin_req_o;
    coin_e      coin_type_o;
    logic       busy_o;
    logic       jam_o;
    logic       overflow_o;

    modport master (
        output vend_i, change_i, coin_ack_i, clear_jam_i,
        input  coin_req_o, coin_type_o, busy_o, jam_o, overflow_o
    );

    modport slave (
        input  vend_i, change_i, coin_ack_i, clear_jam_i,
        output coin_req_o, coin_type_o, busy_o, jam_o, overflow_o
    );

endinterface

// File: rtl/ack_watchdog.sv
// Counts cycles a coin request has been outstanding; expired flags that ACK_TIMEOUT cycles have elapsed.
module ack_watchdog #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_W'(ACK_TIMEOUT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == CNT_W'(ACK_TIMEOUT));

endmodule

// File: rtl/change_dispenser.sv
// Pays owed change to a coin hopper one coin at a time over req/ack, with jam detection.
// Define CHANGE_DISPENSER_DIME_EN for greedy dime-first payout; otherwise nickels only.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int PENDING_W   = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    change_dispenser_if.slave   bus
);

    localparam int SUM_W = PENDING_W + 2;
    localparam logic [PENDING_W-1:0] PENDING_MAX = '1;

    payout_state_e          state_reg, state_next;
    logic [PENDING_W-1:0]   pending_reg, pending_next;
    logic                   overflow_reg, overflow_next;
    coin_e                  coin_type;
    logic                   acked;
    logic                   wd_expired;
    logic [SUM_W-1:0]       added, paid, sum;

`ifdef CHANGE_DISPENSER_DIME_EN
    coin_e coin_type_reg;

    // Coin type is chosen once per request so it stays stable while the hopper works.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            coin_type_reg <= NICKEL;
        end else if ((state_reg == IDLE) && (pending_reg != '0)) begin
            coin_type_reg <= (pending_reg >= PENDING_W'(DIME_VALUE)) ? DIME : NICKEL;
        end
    end

    assign coin_type = coin_type_reg;
`else
    assign coin_type = NICKEL;
`endif

    assign acked = (state_reg == REQ) && bus.coin_ack_i;
    assign added = bus.vend_i ? SUM_W'(clamp_change(bus.change_i)) : '0;
    assign paid  = !acked ? '0 :
                   (coin_type == DIME) ? SUM_W'(DIME_VALUE) : SUM_W'(NICKEL_VALUE);
    assign sum   = {2'b00, pending_reg} + added - paid;

    always_comb begin
        pending_next  = sum[PENDING_W-1:0];
        overflow_next = overflow_reg;
        if (sum > {2'b00, PENDING_MAX}) begin
            pending_next  = PENDING_MAX;
            overflow_next = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pending_reg != '0) state_next = REQ;
            // An ack arriving on the timeout edge still completes the coin.
            REQ:     if (bus.coin_ack_i)    state_next = IDLE;
                     else if (wd_expired)   state_next = JAM;
            JAM:     if (bus.clear_jam_i)   state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
        end
    end

    ack_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en      (state_next == REQ),
        .clr     (state_next != REQ),
        .expired (wd_expired)
    );

    assign bus.coin_req_o  = (state_reg == REQ);
    assign bus.coin_type_o = coin_type;
    assign bus.jam_o       = (state_reg == JAM);
    assign bus.busy_o      = (pending_reg != '0) || (state_reg != IDLE);
    assign bus.overflow_o  = overflow_reg;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout end of the vending datapath. Consumes the dispenser's per-vend change code (number of nickels owed, 0–4) and pays it out coin by coin to an external coin hopper over a req/ack handshake. Accumulates owed change across back-to-back vends and detects a stalled hopper. Sits between the dispensing logic and the physical coin hopper driver.

## Interface
Parameters:
- ACK_TIMEOUT, 15: cycles `coin_req_o` may stay high without `coin_ack_i` before declaring a jam (≥2).
- PENDING_W, 6: width of the owed-change accumulator, in nickels.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- vend_i  input  1  one-cycle pulse: a soda was dispensed this cycle.
- change_i  input  3  nickels owed for this vend (0–4); sampled only when `vend_i`=1; values 5–7 are treated as 4.
- coin_ack_i  input  1  hopper has released the requested coin.
- clear_jam_i  input  1  one-cycle pulse: operator cleared the hopper.
- coin_req_o  output  1  request one coin from the hopper.
- coin_type_o  output  1  0 = nickel, 1 = dime; valid while `coin_req_o`=1.
- busy_o  output  1  pending ≠ 0 or state ≠ IDLE.
- jam_o  output  1  hopper timeout; payout halted.
- overflow_o  output  1  sticky: accumulator saturated.

## Operation
- pending (PENDING_W bits, nickels) next value = pending + added − paid, where added = change_i when `vend_i`=1 (else 0) and paid = 2 for an acked dime, 1 for an acked nickel (else 0). The add and the subtract happen in the same cycle when both events occur.
- Saturation: if the sum exceeds 2^PENDING_W−1, pending clamps to max and `overflow_o` sets. `overflow_o` clears only on reset.
- FSM states:
  - IDLE: if pending ≠ 0, go to REQ. On entry to REQ, latch coin_type = dime if pending ≥ 2 (and dimes are enabled), else nickel.
  - REQ: `coin_req_o`=1 and `coin_type_o` is held stable. On `coin_ack_i`=1, decrement pending and go to IDLE. When the watchdog reaches ACK_TIMEOUT, go to JAM.
  - JAM: `jam_o`=1, `coin_req_o`=0. `vend_i` events still accumulate. On `clear_jam_i`, go to IDLE with pending intact; the unacked coin is re-requested.
- `coin_ack_i` is ignored outside REQ.
- `clear_jam_i` is ignored outside JAM.
- Reset at any time, including mid-REQ: state IDLE, pending 0, all outputs 0, watchdog 0.

## Timing
- All outputs are registered and decoded from state and registers.
- Reset values: `coin_req_o`=0, `coin_type_o`=0, `busy_o`=0, `jam_o`=0, `overflow_o`=0.
- Latency: with `vend_i` sampled at edge N (pending previously 0), pending updates at N, FSM enters REQ at N+1, and `coin_req_o` is high in the cycle after edge N+1.
- Ack sampled at edge M: `coin_req_o` is low after M. The next coin's `coin_req_o` rises after M+1, guaranteeing at least one low cycle between coins.
- Watchdog counts cycles in REQ, starting at 1 on entry. At count = ACK_TIMEOUT with no ack, JAM is entered at that edge. An ack on the same edge wins over the timeout.
- `busy_o` falls at the edge leaving REQ with pending reaching 0.

## Configuration
- `CHANGE_DISPENSER_DIME_EN`:
  - Defined: greedy payout, dimes first while pending ≥ 2.
  - Undefined: nickels only; `coin_type_o` is tied to 0 and the dime decision logic is removed.

## Structure
- Shared package `vending_pkg` holds:
  - `coin_e` (NICKEL=0, DIME=1).
  - `payout_state_e` (IDLE, REQ, JAM).
  - Constants NICKEL_VALUE=1 and DIME_VALUE=2 (in nickel units).
  - MAX_CHANGE_CODE=4.
- Sub-module `ack_watchdog`: a cycle counter with enable and clear inputs and an `expired` output at the ACK_TIMEOUT parameter. Instantiated once.

## Test plan
- `vend_i`=1, `change_i`=3, ack one cycle after each req → dime then nickel (`coin_type_o` 1, 0). `busy_o` drops after the second ack; `overflow_o`=0.
- `vend_i`=1, `change_i`=0 → `coin_req_o` never rises, `busy_o` stays 0.
- In REQ (dime, pending 3), `vend_i` with `change_i`=4 in the same cycle as `coin_ack_i` → pending = 5. Payout continues dime, dime, nickel.
- Hold `coin_ack_i`=0 for 15 cycles → `jam_o`=1, `coin_req_o`=0, pending unchanged. Then `clear_jam_i` → same coin re-requested and completes normally.
- Assert `rst_ni`=0 mid-REQ with pending 4 → all outputs 0 immediately. After release with no vend, no request is issued.
- Build without `CHANGE_DISPENSER_DIME_EN`, `change_i`=4 → four nickel requests, `coin_type_o`=0 throughout.
